// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen -- free-running VGA raster timing generator.
//
// Produces the hcount/vcount/de raster consumed by the pixel pattern
// generator, plus hsync/vsync for the connector. A run/stop FSM
// (IDLE / RUN / DRAIN) starts the raster on enable and, when enable is
// dropped, finishes the current frame before stopping. Frame/line markers
// (sof, eol) and a wrapping completed-frame counter are also provided.
//
// Ports:
//   clk_pix    in   1  pixel clock
//   resetn     in   1  synchronous active-low reset
//   enable     in   1  run request (level-sensitive)
//   hcount     out 10  horizontal position, 0..H_TOTAL-1
//   vcount     out 10  vertical position, 0..V_TOTAL-1
//   de         out  1  active video
//   hsync      out  1  horizontal sync, asserted level HSYNC_POL
//   vsync      out  1  vertical sync, asserted level VSYNC_POL
//   sof        out  1  one-clock pulse at pixel (0,0)
//   eol        out  1  one-clock pulse at last visible pixel of a visible line
//   frame_cnt  out 16  completed-frame counter, wraps
//   busy       out  1  high while the raster is running
//
// Build option:
//   VGA_SYNC_PIPE_ALIGN_EN -- when defined, de/hsync/vsync/sof/eol pass
//   through one extra register stage so they line up with the registered
//   RGB output of the pattern generator. When undefined they are coincident
//   with hcount/vcount.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk_pix,
  input  logic        resetn,
  input  logic        enable,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        sof,
  output logic        eol,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_EOL    = 10'(H_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;
  logic        busy_q, busy_d;

  logic        frame_end_s;
  logic        active_s;
  logic        h_vis_s;
  logic        v_vis_s;

  assign frame_end_s = (hcount_q == H_LAST) && (vcount_q == V_LAST);

  // FSM state register.
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DRAIN only leaves for IDLE on the last pixel of a frame,
  // so a dropped enable never truncates the raster.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) state_d = ST_DRAIN;
        else         state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (enable)           state_d = ST_RUN;
        else if (frame_end_s) state_d = ST_IDLE;
        else                  state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next counter values and markers decoded from them, so the
  // registered markers line up with the registered counters.
  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_IDLE) begin
      // Held at the origin; the first RUN cycle therefore shows (0,0).
      hcount_d = 10'd0;
      vcount_d = 10'd0;
    end else if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      if (vcount_q == V_LAST) begin
        vcount_d    = 10'd0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 10'd1;
    end

    active_s = (state_d != ST_IDLE);
    h_vis_s  = (hcount_d < H_ACT);
    v_vis_s  = (vcount_d < V_ACT);

    busy_d = active_s;
    de_d   = active_s && h_vis_s && v_vis_s;
    eol_d  = active_s && v_vis_s && (hcount_d == H_EOL);
    sof_d  = active_s && (hcount_d == 10'd0) && (vcount_d == 10'd0);

    if (active_s && (hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) begin
      hsync_d = HSYNC_POL;
    end else begin
      hsync_d = ~HSYNC_POL;
    end

    if (active_s && (vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) begin
      vsync_d = VSYNC_POL;
    end else begin
      vsync_d = ~VSYNC_POL;
    end
  end

  // Counter and marker registers.
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      hcount_q    <= 10'd0;
      vcount_q    <= 10'd0;
      frame_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
      de_q        <= 1'b0;
      eol_q       <= 1'b0;
      sof_q       <= 1'b0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      de_q        <= de_d;
      eol_q       <= eol_d;
      sof_q       <= sof_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;

`ifdef VGA_SYNC_PIPE_ALIGN_EN
  logic de_p_q, hsync_p_q, vsync_p_q, sof_p_q, eol_p_q;

  // Extra delay stage so video markers match the pattern generator's RGB register.
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      de_p_q    <= 1'b0;
      eol_p_q   <= 1'b0;
      sof_p_q   <= 1'b0;
      hsync_p_q <= ~HSYNC_POL;
      vsync_p_q <= ~VSYNC_POL;
    end else begin
      de_p_q    <= de_q;
      eol_p_q   <= eol_q;
      sof_p_q   <= sof_q;
      hsync_p_q <= hsync_q;
      vsync_p_q <= vsync_q;
    end
  end

  assign de    = de_p_q;
  assign hsync = hsync_p_q;
  assign vsync = vsync_p_q;
  assign sof   = sof_p_q;
  assign eol   = eol_p_q;
`else
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign sof   = sof_q;
  assign eol   = eol_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// Testbench for vga_sync_gen, using a shrunken raster (15 x 10 clocks,
// 150 clocks per frame) so multi-frame behaviour is cheap to exercise.
// Timing: H 8 active / 2 FP / 3 sync / 2 BP; V 6 active / 1 FP / 2 sync / 1 BP.
// A behavioural model keyed on a linear pixel index feeds a scoreboard that
// is compared every clock; a table of hand-derived checkpoints and a few
// counted sequences cover the documented corner cases.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int HA = 8,  HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;   // 15
  localparam int VT = VA + VFP + VS + VBP;   // 10
  localparam int FRAME = HT * VT;            // 150

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        eol;
    logic        busy;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    string name;
    logic  rn;
    logic  en;
    int    n;
    obs_t  exp;
  } vec_t;

  logic        clk_pix = 1'b0;
  logic        resetn;
  logic        enable;
  logic [9:0]  hcount, vcount;
  logic        de, hsync, vsync, sof, eol, busy;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];

  // model state
  int          m_st  = 0;   // 0 idle, 1 run, 2 drain
  int          m_pos = 0;
  logic [15:0] m_fc  = 16'd0;
  obs_t        m_prev;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_pix(clk_pix), .resetn(resetn), .enable(enable),
    .hcount(hcount), .vcount(vcount), .de(de), .hsync(hsync), .vsync(vsync),
    .sof(sof), .eol(eol), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic obs_t mk(input int h, input int v, input logic de_e,
                              input logic hs_e, input logic vs_e, input logic sof_e,
                              input logic eol_e, input logic busy_e, input int fc);
    obs_t o;
    o.h = 10'(h); o.v = 10'(v); o.de = de_e; o.hs = hs_e; o.vs = vs_e;
    o.sof = sof_e; o.eol = eol_e; o.busy = busy_e; o.fc = 16'(fc);
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.h = hcount; o.v = vcount; o.de = de; o.hs = hsync; o.vs = vsync;
    o.sof = sof; o.eol = eol; o.busy = busy; o.fc = frame_cnt;
    return o;
  endfunction

  // Advance the reference model across one clock edge and return expected outputs.
  task automatic model_edge(input logic rn, input logic en, output obs_t e);
    bit   last;
    int   h, v;
    obs_t u;
    if (!rn) begin
      m_st = 0; m_pos = 0; m_fc = 16'd0;
    end else if (m_st == 0) begin
      if (en) begin m_st = 1; m_pos = 0; end
    end else begin
      last  = (m_pos == FRAME - 1);
      m_pos = last ? 0 : m_pos + 1;
      if (last) m_fc = m_fc + 16'd1;
      if (m_st == 1) m_st = en ? 1 : 2;
      else           m_st = en ? 1 : (last ? 0 : 2);
    end
    h = m_pos % HT;
    v = m_pos / HT;
    u.h    = 10'(h);
    u.v    = 10'(v);
    u.busy = (m_st != 0);
    u.fc   = m_fc;
    u.de   = u.busy && (h < HA) && (v < VA);
    u.eol  = u.busy && (v < VA) && (h == HA - 1);
    u.sof  = u.busy && (m_pos == 0);
    u.hs   = !(u.busy && (h >= HA + HFP) && (h < HA + HFP + HS));
    u.vs   = !(u.busy && (v >= VA + VFP) && (v < VA + VFP + VS));
    e = u;
`ifdef VGA_SYNC_PIPE_ALIGN_EN
    if (!rn) begin
      e.de = 1'b0; e.eol = 1'b0; e.sof = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      e.de = m_prev.de; e.eol = m_prev.eol; e.sof = m_prev.sof;
      e.hs = m_prev.hs; e.vs = m_prev.vs;
    end
`endif
    m_prev = u;
  endtask

  // One clock: drive inputs, push model expectation, then pop and compare.
  task automatic step(input logic rn, input logic en);
    obs_t e, a;
    @(negedge clk_pix);
    resetn = rn;
    enable = en;
    model_edge(rn, en, e);
    exp_q.push_back(e);
    @(posedge clk_pix);
    #1;
    a = sample_dut();
    e = exp_q.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL scoreboard t=%0t got h=%0d v=%0d de=%b hs=%b vs=%b sof=%b eol=%b busy=%b fc=%0d want h=%0d v=%0d de=%b hs=%b vs=%b sof=%b eol=%b busy=%b fc=%0d",
               $time, a.h, a.v, a.de, a.hs, a.vs, a.sof, a.eol, a.busy, a.fc,
               e.h, e.v, e.de, e.hs, e.vs, e.sof, e.eol, e.busy, e.fc);
    end
  endtask

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  initial begin
    vec_t  vt[$];
    obs_t  a, mask;
    logic [41:0] diff;
    int hs_n, vs_n, de_n, eol_n, sof_n, busy_n, last_sof, sof_gap;
    int ph, pv;

    resetn = 1'b0;
    enable = 1'b0;

    // name, resetn, enable, cycles, expected {h v de hs vs sof eol busy fc}
    vt.push_back('{"reset",          1'b0, 1'b0,   2, mk( 0, 0, 0, 1, 1, 0, 0, 0, 0)});
    vt.push_back('{"first_run",      1'b1, 1'b1,   1, mk( 0, 0, 1, 1, 1, 1, 0, 1, 0)});
    vt.push_back('{"last_active_px", 1'b1, 1'b1,   7, mk( 7, 0, 1, 1, 1, 0, 1, 1, 0)});
    vt.push_back('{"first_blank_px", 1'b1, 1'b1,   1, mk( 8, 0, 0, 1, 1, 0, 0, 1, 0)});
    vt.push_back('{"hsync_start",    1'b1, 1'b1,   2, mk(10, 0, 0, 0, 1, 0, 0, 1, 0)});
    vt.push_back('{"hsync_end",      1'b1, 1'b1,   2, mk(12, 0, 0, 0, 1, 0, 0, 1, 0)});
    vt.push_back('{"hsync_off",      1'b1, 1'b1,   1, mk(13, 0, 0, 1, 1, 0, 0, 1, 0)});
    vt.push_back('{"line_wrap",      1'b1, 1'b1,   2, mk( 0, 1, 1, 1, 1, 0, 0, 1, 0)});
    vt.push_back('{"vsync_line",     1'b1, 1'b1,  90, mk( 0, 7, 0, 1, 0, 0, 0, 1, 0)});
    vt.push_back('{"frame_last_px",  1'b1, 1'b1,  44, mk(14, 9, 0, 1, 1, 0, 0, 1, 0)});
    vt.push_back('{"frame_wrap",     1'b1, 1'b1,   1, mk( 0, 0, 1, 1, 1, 1, 0, 1, 1)});
    vt.push_back('{"drain_mid",      1'b1, 1'b0,  20, mk( 5, 1, 1, 1, 1, 0, 0, 1, 1)});
    vt.push_back('{"drain_last_px",  1'b1, 1'b0, 129, mk(14, 9, 0, 1, 1, 0, 0, 1, 1)});
    vt.push_back('{"drain_to_idle",  1'b1, 1'b0,   1, mk( 0, 0, 0, 1, 1, 0, 0, 0, 2)});
    vt.push_back('{"idle_hold",      1'b1, 1'b0,   5, mk( 0, 0, 0, 1, 1, 0, 0, 0, 2)});
    vt.push_back('{"restart_sof",    1'b1, 1'b1,   1, mk( 0, 0, 1, 1, 1, 1, 0, 1, 2)});
    vt.push_back('{"run_line2",      1'b1, 1'b1,  30, mk( 0, 2, 1, 1, 1, 0, 0, 1, 2)});
    vt.push_back('{"blip_off",       1'b1, 1'b0,   3, mk( 3, 2, 1, 1, 1, 0, 0, 1, 2)});
    vt.push_back('{"blip_on",        1'b1, 1'b1,   3, mk( 6, 2, 1, 1, 1, 0, 0, 1, 2)});
    vt.push_back('{"blip_frame_end", 1'b1, 1'b1, 113, mk(14, 9, 0, 1, 1, 0, 0, 1, 2)});
    vt.push_back('{"blip_wrap",      1'b1, 1'b1,   1, mk( 0, 0, 1, 1, 1, 1, 0, 1, 3)});
    vt.push_back('{"pre_reset",      1'b1, 1'b1,  35, mk( 5, 2, 1, 1, 1, 0, 0, 1, 3)});
    vt.push_back('{"reset_mid",      1'b0, 1'b1,   1, mk( 0, 0, 0, 1, 1, 0, 0, 0, 0)});
    vt.push_back('{"post_reset_idle",1'b1, 1'b0,   3, mk( 0, 0, 0, 1, 1, 0, 0, 0, 0)});

    mask = '1;
`ifdef VGA_SYNC_PIPE_ALIGN_EN
    mask.de = 1'b0; mask.hs = 1'b0; mask.vs = 1'b0; mask.sof = 1'b0; mask.eol = 1'b0;
`endif

    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].n; k++) step(vt[i].rn, vt[i].en);
      a = sample_dut();
      diff = (a ^ vt[i].exp) & mask;
      total++;
      if (diff !== 42'd0) begin
        bad++;
        $display("FAIL %s got h=%0d v=%0d de=%b hs=%b vs=%b sof=%b eol=%b busy=%b fc=%0d want h=%0d v=%0d de=%b hs=%b vs=%b sof=%b eol=%b busy=%b fc=%0d",
                 vt[i].name, a.h, a.v, a.de, a.hs, a.vs, a.sof, a.eol, a.busy, a.fc,
                 vt[i].exp.h, vt[i].exp.v, vt[i].exp.de, vt[i].exp.hs, vt[i].exp.vs,
                 vt[i].exp.sof, vt[i].exp.eol, vt[i].exp.busy, vt[i].exp.fc);
      end
    end

    // Two full frames from idle: count marker activity and check wraps.
    hs_n = 0; vs_n = 0; de_n = 0; eol_n = 0; sof_n = 0; busy_n = 0;
    last_sof = -1; sof_gap = -1;
    ph = -1; pv = -1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1'b1, 1'b1);
      if (hsync == 1'b0) hs_n++;
      if (vsync == 1'b0) vs_n++;
      if (de)   de_n++;
      if (eol)  eol_n++;
      if (busy) busy_n++;
      if (sof) begin
        sof_n++;
        if (last_sof >= 0) sof_gap = c - last_sof;
        last_sof = c;
      end
      if (ph == HT - 1 && pv == VT - 1) begin
        chk("wrap_h", int'(hcount), 0);
        chk("wrap_v", int'(vcount), 0);
      end
      ph = int'(hcount);
      pv = int'(vcount);
    end
    chk("hsync_clocks",  hs_n,  2 * HS * VT);
    chk("vsync_clocks",  vs_n,  2 * VS * HT);
    chk("de_clocks",     de_n,  2 * HA * VA);
    chk("eol_count",     eol_n, 2 * VA);
    chk("sof_count",     sof_n, 2);
    chk("sof_spacing",   sof_gap, FRAME);
    chk("busy_clocks",   busy_n, 2 * FRAME);
    chk("frame_cnt_1",   int'(frame_cnt), 1);
    step(1'b1, 1'b1);
    chk("frame_cnt_2",   int'(frame_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Free-running VGA raster timing generator, default 640x480@60 on the ~25 MHz pixel clock. Produces the hcount/vcount/de raster that the pixel test-pattern generator consumes, plus hsync/vsync for the connector. Adds run/stop control, frame and line markers, and a frame counter. It is the source end of the hcount/vcount/de interface.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync (0 = active-low)

Ports:
clk_pix  in  1  pixel clock
resetn  in  1  synchronous active-low reset
enable  in  1  run request; level-sensitive
hcount  out  10  horizontal position, 0..H_TOTAL-1
vcount  out  10  vertical position, 0..V_TOTAL-1
de  out  1  active video
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
sof  out  1  one-clock pulse at pixel (0,0)
eol  out  1  one-clock pulse at hcount = H_ACTIVE-1 of an active line
frame_cnt  out  16  completed-frame counter, wraps
busy  out  1  high while the raster is running

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- All outputs are registered. de, hsync, vsync, sof and eol are decoded from the next-state counter values, so they align with hcount/vcount in the same cycle.
- Reset (resetn=0 at a clock edge) sets: hcount=0, vcount=0, de=0, sof=0, eol=0, frame_cnt=0, busy=0. hsync=~HSYNC_POL and vsync=~VSYNC_POL (inactive). Reset takes priority over everything, including mid-line and mid-frame.
- Run FSM has three states:
  - IDLE: counters held at 0,0; de=0; syncs inactive. If enable=1, go to RUN. On the first RUN cycle the outputs show pixel (0,0) with sof=1 and de=1.
  - RUN: each clock hcount increments. At H_TOTAL-1, hcount wraps to 0 and vcount increments. At (H_TOTAL-1, V_TOTAL-1) both wrap to 0, frame_cnt increments by 1 (mod 2^16) and sof pulses. If enable=0 in RUN, go to DRAIN.
  - DRAIN: keep counting. If enable returns to 1 before the frame ends, go back to RUN with no disturbance to the raster. At (H_TOTAL-1, V_TOTAL-1), frame_cnt increments and the FSM goes to IDLE. The next cycle shows counters 0,0, busy=0, no sof.
- busy=1 in RUN and DRAIN.
- de=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE, in RUN/DRAIN only.
- hsync is asserted iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync is asserted for whole lines V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC-1 (490..491), for every hcount on those lines.
- eol is asserted only on lines where vcount<V_ACTIVE.
- Frame is never truncated by enable; only resetn aborts a frame.

Optional Feature:
Macro VGA_SYNC_PIPE_ALIGN_EN.
- Defined: de, hsync, vsync, sof and eol are delayed one extra clk_pix register stage relative to hcount/vcount. This matches the one-cycle registered RGB output of the pattern generator. Reset also clears the delay stage to the inactive values.
- Undefined: these outputs are coincident with hcount/vcount as described above.

Test Plan:
1. Reset, then enable=1 -> first RUN cycle: hcount=0, vcount=0, sof=1, de=1. de=1 through hcount=639 and 0 at hcount=640. eol=1 only at hcount=639.
2. Run one line -> hsync=0 exactly for hcount 656..751 (96 clocks). Over a frame, vsync=0 exactly for vcount 490..491 (1600 clocks). de=0 for all of vcount 480..524.
3. Run two frames -> (799,524) is followed by (0,0). frame_cnt goes 0->1->2. sof is spaced exactly 420000 clocks apart.
4. Drop enable at vcount=100 -> raster completes through (799,524), frame_cnt+1, then busy=0 with counters at 0,0. Re-raise enable -> sof on the next RUN cycle.
5. Drop then raise enable within a frame -> no raster discontinuity and no extra frame_cnt increment.
6. Assert resetn=0 at hcount=300, vcount=200 -> next cycle all outputs are at reset values and frame_cnt=0. With VGA_SYNC_PIPE_ALIGN_EN defined, de rises one clock after hcount=0 is shown.
